// File: rtl/int_ctrl_if.sv
// Interrupt sequencer <-> CPU fetch/PC stage bundle.
// master: the interrupt unit; slave: the CPU side.
interface int_ctrl_if #(
    parameter int PC_W  = 8,
    parameter int CCR_W = 4
);
    logic             int_sig;
    logic             pipe_busy;
    logic [PC_W-1:0]  pc_ret;
    logic [CCR_W-1:0] ccr_in;
    logic             rti_ex;
    logic [PC_W-1:0]  vec_data;
    logic             flush;
    logic             stall_fetch;
    logic             vec_rd;
    logic [PC_W-1:0]  vec_addr;
    logic             pc_load;
    logic [PC_W-1:0]  pc_load_val;
    logic             ccr_restore;
    logic [CCR_W-1:0] ccr_restore_val;
    logic             in_isr;

    modport master (
        input  int_sig, pipe_busy, pc_ret, ccr_in, rti_ex, vec_data,
        output flush, stall_fetch, vec_rd, vec_addr, pc_load,
        output pc_load_val, ccr_restore, ccr_restore_val, in_isr
    );

    modport slave (
        output int_sig, pipe_busy, pc_ret, ccr_in, rti_ex, vec_data,
        input  flush, stall_fetch, vec_rd, vec_addr, pc_load,
        input  pc_load_val, ccr_restore, ccr_restore_val, in_isr
    );
endinterface

// File: rtl/int_ctrl_unit.sv
// Interrupt sequencer: edge capture, flush, vector fetch, PC/CCR shadow, RTI.
// INT_CCR_SAVE_EN: when defined, CCR is shadowed on entry and restored on RTI.
module int_ctrl_unit #(
    parameter int              PC_W     = 8,
    parameter int              CCR_W    = 4,
    parameter logic [PC_W-1:0] VEC_ADDR = 8'h01
) (
    input  logic       clk,
    input  logic       rstn,
    int_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, FLUSH, VEC, LOAD, ISR, RET
    } state_t;

    state_t          state;
    logic            int_q;
    logic            pending;
    logic [PC_W-1:0] saved_pc;
    logic            flush_q;
    logic            stall_q;
    logic            vec_rd_q;
    logic            pc_load_q;
    logic            in_isr_q;
    logic            edge_det;
    logic            go;

    assign edge_det = bus.int_sig & ~int_q;
    assign go       = (pending | edge_det) & ~bus.pipe_busy;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            int_q     <= 1'b1;
            pending   <= 1'b0;
            saved_pc  <= '0;
            flush_q   <= 1'b0;
            stall_q   <= 1'b0;
            vec_rd_q  <= 1'b0;
            pc_load_q <= 1'b0;
            in_isr_q  <= 1'b0;
        end else begin
            int_q     <= bus.int_sig;
            // set wins over the clear in LOAD
            pending   <= (pending & (state != LOAD)) | edge_det;
            flush_q   <= 1'b0;
            stall_q   <= 1'b0;
            vec_rd_q  <= 1'b0;
            pc_load_q <= 1'b0;
            in_isr_q  <= 1'b0;
            unique case (state)
                IDLE: if (go) begin
                    state    <= FLUSH;
                    saved_pc <= bus.pc_ret;
                    flush_q  <= 1'b1;
                    stall_q  <= 1'b1;
                end
                FLUSH: begin
                    state    <= VEC;
                    stall_q  <= 1'b1;
                    vec_rd_q <= 1'b1;
                end
                VEC: begin
                    state     <= LOAD;
                    pc_load_q <= 1'b1;
                end
                LOAD: begin
                    state    <= ISR;
                    in_isr_q <= 1'b1;
                end
                ISR: begin
                    in_isr_q <= 1'b1;
                    if (bus.rti_ex) begin
                        state     <= RET;
                        pc_load_q <= 1'b1;
                        flush_q   <= 1'b1;
                    end
                end
                RET: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INT_CCR_SAVE_EN
    logic [CCR_W-1:0] saved_ccr;
    logic             restore_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            saved_ccr <= '0;
            restore_q <= 1'b0;
        end else begin
            if (state == IDLE && go)
                saved_ccr <= bus.ccr_in;
            restore_q <= (state == ISR) && bus.rti_ex;
        end
    end

    assign bus.ccr_restore     = restore_q;
    assign bus.ccr_restore_val = restore_q ? saved_ccr : '0;
`else
    wire unused_ccr = ^bus.ccr_in;

    assign bus.ccr_restore     = 1'b0;
    assign bus.ccr_restore_val = '0;
`endif

    // vec_data is only valid during LOAD, so the value mux stays combinational
    always_comb begin
        bus.pc_load_val = '0;
        if (pc_load_q)
            bus.pc_load_val = (state == RET) ? saved_pc : bus.vec_data;
    end

    assign bus.flush       = flush_q;
    assign bus.stall_fetch = stall_q;
    assign bus.vec_rd      = vec_rd_q;
    assign bus.vec_addr    = VEC_ADDR;
    assign bus.pc_load     = pc_load_q;
    assign bus.in_isr      = in_isr_q;
endmodule

// File: tb/tb_int_ctrl_unit.sv
// Directed table-driven bench for int_ctrl_unit.
// Expected CCR restore values follow INT_CCR_SAVE_EN.
module tb_int_ctrl_unit;
`ifdef INT_CCR_SAVE_EN
    localparam bit CCR_EN = 1'b1;
`else
    localparam bit CCR_EN = 1'b0;
`endif

    typedef struct {
        logic        is;
        logic        bz;
        logic [7:0]  pc;
        logic [3:0]  cc;
        logic        rt;
        logic [7:0]  vd;
        logic [25:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    vec_t tbl[$];

    int_ctrl_if #(.PC_W(8), .CCR_W(4)) bus ();

    int_ctrl_unit #(.PC_W(8), .CCR_W(4), .VEC_ADDR(8'h01)) u_dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] cv(input logic [3:0] v);
        return CCR_EN ? v : 4'h0;
    endfunction

    function automatic logic [25:0] pk(
        input logic ef, es, evr, epl, input logic [7:0] eplv,
        input logic ecr, input logic [3:0] ecrv, input logic eisr);
        return {ef, es, evr, epl, eplv, ecr, ecrv, eisr, 8'h01};
    endfunction

    function automatic logic [25:0] act();
        return {bus.flush, bus.stall_fetch, bus.vec_rd, bus.pc_load,
                bus.pc_load_val, bus.ccr_restore, bus.ccr_restore_val,
                bus.in_isr, bus.vec_addr};
    endfunction

    task automatic row(input logic is, bz, input logic [7:0] pc,
                       input logic [3:0] cc, input logic rt,
                       input logic [7:0] vd, input logic [25:0] e);
        vec_t v;
        v.is = is; v.bz = bz; v.pc = pc; v.cc = cc;
        v.rt = rt; v.vd = vd; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [25:0] e);
        logic [25:0] a;
        a = act();
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, a, e);
    endtask

    task automatic drive(input logic is, bz, input logic [7:0] pc,
                         input logic [3:0] cc, input logic rt,
                         input logic [7:0] vd);
        bus.int_sig = is; bus.pipe_busy = bz; bus.pc_ret = pc;
        bus.ccr_in = cc; bus.rti_ex = rt; bus.vec_data = vd;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [25:0] z, fl, vc, is_;
        z   = pk(0, 0, 0, 0, 8'h00, 0, 4'h0, 0);
        fl  = pk(1, 1, 0, 0, 8'h00, 0, 4'h0, 0);
        vc  = pk(0, 1, 1, 0, 8'h00, 0, 4'h0, 0);
        is_ = pk(0, 0, 0, 0, 8'h00, 0, 4'h0, 1);

        for (int i = 0; i < 10; i++) row(1, 0, 8'h00, 4'h0, 0, 8'h00, z);
        row(0, 0, 8'h00, 4'h0, 0, 8'h00, z);
        row(1, 0, 8'h11, 4'hA, 0, 8'h00, fl);
        row(0, 0, 8'h22, 4'h3, 0, 8'h00, vc);
        row(0, 0, 8'h22, 4'h3, 0, 8'h40, pk(0, 0, 0, 1, 8'h40, 0, 4'h0, 0));
        row(0, 0, 8'h22, 4'h3, 0, 8'h40, is_);
        row(0, 0, 8'h22, 4'h3, 0, 8'h00, is_);
        row(0, 0, 8'h22, 4'h3, 1, 8'h00,
            pk(1, 0, 0, 1, 8'h11, CCR_EN, cv(4'hA), 1));
        row(0, 0, 8'h22, 4'h3, 0, 8'h00, z);
        row(0, 0, 8'h22, 4'h3, 1, 8'h00, z);
        row(0, 0, 8'h22, 4'h3, 0, 8'h00, z);
        row(1, 1, 8'h30, 4'h5, 0, 8'h00, z);
        for (int i = 0; i < 4; i++)
            row(0, 1, 8'h31 + 8'(i), 4'h5, 0, 8'h00, z);
        row(0, 0, 8'h35, 4'h5, 0, 8'h00, fl);
        row(0, 0, 8'h36, 4'h6, 0, 8'h00, vc);
        row(0, 0, 8'h36, 4'h6, 0, 8'h40, pk(0, 0, 0, 1, 8'h40, 0, 4'h0, 0));
        row(0, 0, 8'h36, 4'h6, 0, 8'h00, is_);
        row(0, 0, 8'h36, 4'h6, 1, 8'h00,
            pk(1, 0, 0, 1, 8'h35, CCR_EN, cv(4'h5), 1));
        row(0, 0, 8'h36, 4'h6, 0, 8'h00, z);
        row(1, 0, 8'h50, 4'h3, 0, 8'h00, fl);
        row(0, 0, 8'h51, 4'h9, 0, 8'h00, vc);
        row(0, 0, 8'h51, 4'h9, 0, 8'h40, pk(0, 0, 0, 1, 8'h40, 0, 4'h0, 0));
        row(0, 0, 8'h51, 4'h9, 0, 8'h00, is_);
        row(1, 0, 8'h66, 4'h9, 0, 8'h00, is_);
        row(0, 0, 8'h66, 4'h9, 0, 8'h00, is_);
        row(0, 0, 8'h66, 4'h9, 1, 8'h00,
            pk(1, 0, 0, 1, 8'h50, CCR_EN, cv(4'h3), 1));
        row(0, 0, 8'h70, 4'h9, 0, 8'h00, z);
        row(0, 0, 8'h77, 4'hC, 0, 8'h00, fl);
        row(0, 0, 8'h78, 4'h1, 0, 8'h00, vc);
        row(0, 0, 8'h78, 4'h1, 0, 8'h40, pk(0, 0, 0, 1, 8'h40, 0, 4'h0, 0));
        row(0, 0, 8'h78, 4'h1, 0, 8'h00, is_);
        row(0, 0, 8'h78, 4'h1, 1, 8'h00,
            pk(1, 0, 0, 1, 8'h77, CCR_EN, cv(4'hC), 1));
        row(0, 0, 8'h78, 4'h1, 0, 8'h00, z);
        row(1, 0, 8'h88, 4'hF, 0, 8'h00, fl);
        row(0, 0, 8'h89, 4'h2, 0, 8'h00, vc);
        row(0, 0, 8'h89, 4'h2, 0, 8'h40, pk(0, 0, 0, 1, 8'h40, 0, 4'h0, 0));
        row(0, 0, 8'h89, 4'h2, 0, 8'h00, is_);

        drive(1, 0, 8'h00, 4'h0, 0, 8'h00);
        rstn = 1'b0;
        repeat (3) step();
        check("reset", z);
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].is, tbl[i].bz, tbl[i].pc, tbl[i].cc,
                  tbl[i].rt, tbl[i].vd);
            step();
            check($sformatf("row%0d", i), tbl[i].exp);
        end

        drive(1, 0, 8'h90, 4'hF, 0, 8'h00);
        rstn = 1'b0;
        step();
        check("rst_mid_isr", z);
        rstn = 1'b1;
        drive(0, 0, 8'h90, 4'hF, 0, 8'h00);
        step();
        check("post_rst_idle", z);
        drive(0, 0, 8'h90, 4'hF, 1, 8'h00);
        step();
        check("rti_after_rst", z);
        drive(0, 0, 8'h90, 4'hF, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("no_pending%0d", i), z);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
